stopwatch_tracker: RTL and testbench

Parametrised elapsed/remaining-time counter for the stopwatch datapath, replacing the fixed 13-bit up-only seconds counter. Advances once per `tick` edge while running, counts up (stopwatch) or down (timer), supports preset load, lap capture and expiry detection. Sits between the button/mode control logic and the display formatter, which reads `seconds_o`, `lap_o` and `state_o`.

---
 rtl/stopwatch_tracker.sv | 123 ++++++++++++
 tb/tb_stopwatch_tracker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_tracker.sv
// Elapsed/remaining-time counter for the stopwatch datapath: up/down count, preset load, lap capture, expiry.
// Optional lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise lap_o/lap_valid_o are tied low.
//
// state | meaning
// IDLE  | after reset or load, waiting for run
// RUN   | counting once per tick edge
// HOLD  | paused by run dropping, value held
// DONE  | countdown reached 0 on a running edge; only load/reset exit
module stopwatch_tracker #(
   parameter int unsigned WIDTH     = 13,
   parameter int unsigned MAX_COUNT = 5999
) (
   input  logic             tick,
   input  logic             reset,
   input  logic             run,
   input  logic             dir_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             lap,
   output logic [WIDTH-1:0] seconds_o,
   output logic [WIDTH-1:0] lap_o,
   output logic             lap_valid_o,
   output logic             wrap_o,
   output logic             expired_o,
   output logic [1:0]       state_o
);

   if (64'(MAX_COUNT) >= (64'd1 << WIDTH)) begin : g_bad_max
      $error("stopwatch_tracker: MAX_COUNT does not fit in WIDTH bits");
   end

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             expired_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (load) begin
         cnt_d   = (load_value > MAX_W) ? MAX_W : load_value;
         state_d = IDLE;
      end else if (state_q != DONE) begin
         if (run) begin
            state_d = RUN;
            if (!dir_down) begin
               if (cnt_q == MAX_W) begin
                  cnt_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (cnt_q == '0) begin
               // value already at 0 on a running edge: expire without changing it
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end else if (state_q == RUN) begin
            state_d = HOLD;
         end
      end
   end

   always_ff @(posedge tick) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wrap_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wrap_q    <= wrap_d;
         expired_q <= (state_d == DONE);
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [WIDTH-1:0] lap_q, lap_d;
   logic             lap_valid_q, lap_valid_d;

   // capture uses the pre-edge count, independent of load/count priority
   always_comb begin
      lap_d       = lap ? cnt_q : lap_q;
      lap_valid_d = lap;
   end

   always_ff @(posedge tick) begin
      if (reset) begin
         lap_q       <= '0;
         lap_valid_q <= 1'b0;
      end else begin
         lap_q       <= lap_d;
         lap_valid_q <= lap_valid_d;
      end
   end

   assign lap_o       = lap_q;
   assign lap_valid_o = lap_valid_q;
`else
   logic lap_unused;
   assign lap_unused  = lap;
   assign lap_o       = '0;
   assign lap_valid_o = 1'b0;
`endif

   assign seconds_o = cnt_q;
   assign wrap_o    = wrap_q;
   assign expired_o = expired_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_stopwatch_tracker.sv
// Directed bench for stopwatch_tracker: expected outputs queued per step, popped and checked after each tick edge.
// Lap expectations follow STOPWATCH_LAP_EN the same way the design build does.
module tb_stopwatch_tracker;

   localparam int W = 13;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic         tick = 1'b0;
   logic         reset = 1'b0;
   logic         run = 1'b0;
   logic         dir_down = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_value = '0;
   logic         lap = 1'b0;
   logic [W-1:0] seconds_o;
   logic [W-1:0] lap_o;
   logic         lap_valid_o;
   logic         wrap_o;
   logic         expired_o;
   logic [1:0]   state_o;

   stopwatch_tracker #(.WIDTH(W), .MAX_COUNT(5999)) dut (
      .tick        (tick),
      .reset       (reset),
      .run         (run),
      .dir_down    (dir_down),
      .load        (load),
      .load_value  (load_value),
      .lap         (lap),
      .seconds_o   (seconds_o),
      .lap_o       (lap_o),
      .lap_valid_o (lap_valid_o),
      .wrap_o      (wrap_o),
      .expired_o   (expired_o),
      .state_o     (state_o)
   );

   always #5 tick = ~tick;

   typedef struct {
      logic [W-1:0] sec;
      logic [1:0]   st;
      logic         wrap;
      logic         lapv;
      logic [W-1:0] lapval;
      string        tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [W-1:0] lapx(input int v);
      return LAP_EN ? W'(v) : '0;
   endfunction

   function automatic logic lapvx(input bit v);
      return LAP_EN & v;
   endfunction

   task automatic chk(input string tag, input string what, input int obs, input int exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp_v);
   endtask

   task automatic step(input string tag, input bit rst, input bit r, input bit dn,
                       input bit ld, input int lv, input bit lp,
                       input int e_sec, input logic [1:0] e_st, input bit e_wrap,
                       input bit e_lapv, input int e_lap);
      exp_t e;
      @(negedge tick);
      reset      = rst;
      run        = r;
      dir_down   = dn;
      load       = ld;
      load_value = W'(lv);
      lap        = lp;
      e.sec    = W'(e_sec);
      e.st     = e_st;
      e.wrap   = e_wrap;
      e.lapv   = lapvx(e_lapv);
      e.lapval = lapx(e_lap);
      e.tag    = tag;
      exp_q.push_back(e);
      @(posedge tick);
      #1;
      e = exp_q.pop_front();
      chk(e.tag, "seconds", int'(seconds_o), int'(e.sec));
      chk(e.tag, "state", int'(state_o), int'(e.st));
      chk(e.tag, "wrap", int'(wrap_o), int'(e.wrap));
      chk(e.tag, "expired", int'(expired_o), int'(e.st == S_DONE));
      chk(e.tag, "lap_valid", int'(lap_valid_o), int'(e.lapv));
      chk(e.tag, "lap", int'(lap_o), int'(e.lapval));
   endtask

   initial begin
      // tag, rst, run, dn, ld, lv, lap, sec, state, wrap, lapv, lap_o
      step("reset0", 1, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
      step("idle_norun", 0, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
      for (int i = 1; i <= 37; i++) step("up37", 0, 1, 0, 0, 0, 0, i, S_RUN, 0, 0, 0);
      step("reset_mid", 1, 1, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0);
      step("resume1", 0, 1, 0, 0, 0, 0, 1, S_RUN, 0, 0, 0);
      step("resume2", 0, 1, 0, 0, 0, 0, 2, S_RUN, 0, 0, 0);

      step("ld5998", 0, 1, 0, 1, 5998, 0, 5998, S_IDLE, 0, 0, 0);
      step("wrap_max", 0, 1, 0, 0, 0, 0, 5999, S_RUN, 0, 0, 0);
      step("wrap_zero", 0, 1, 0, 0, 0, 0, 0, S_RUN, 1, 0, 0);
      step("wrap_one", 0, 1, 0, 0, 0, 0, 1, S_RUN, 0, 0, 0);
      step("dir_flip", 0, 1, 1, 0, 0, 0, 0, S_RUN, 0, 0, 0);

      step("ld2", 0, 0, 1, 1, 2, 0, 2, S_IDLE, 0, 0, 0);
      step("dn1", 0, 1, 1, 0, 0, 0, 1, S_RUN, 0, 0, 0);
      step("dn0", 0, 1, 1, 0, 0, 0, 0, S_RUN, 0, 0, 0);
      step("done", 0, 1, 1, 0, 0, 0, 0, S_DONE, 0, 0, 0);
      step("done_norun", 0, 0, 1, 0, 0, 0, 0, S_DONE, 0, 0, 0);
      step("done_up", 0, 1, 0, 0, 0, 0, 0, S_DONE, 0, 0, 0);
      step("done_hold", 0, 0, 0, 0, 0, 0, 0, S_DONE, 0, 0, 0);
      step("done_ld10", 0, 1, 0, 1, 10, 0, 10, S_IDLE, 0, 0, 0);

      step("ld0", 0, 0, 0, 1, 0, 0, 0, S_IDLE, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step("pause_up", 0, 1, 0, 0, 0, 0, i, S_RUN, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("pause_hold", 0, 0, 0, 0, 0, 0, 5, S_HOLD, 0, 0, 0);
      step("resume6", 0, 1, 0, 0, 0, 0, 6, S_RUN, 0, 0, 0);
      step("hold_again", 0, 0, 0, 0, 0, 0, 6, S_HOLD, 0, 0, 0);
      step("hold_ld", 0, 0, 0, 1, 100, 0, 100, S_IDLE, 0, 0, 0);

      step("clamp", 0, 1, 0, 1, 8000, 0, 5999, S_IDLE, 0, 0, 0);
      step("clamp_exact", 0, 1, 0, 1, 5999, 0, 5999, S_IDLE, 0, 0, 0);

      step("ld42", 0, 0, 0, 1, 42, 0, 42, S_IDLE, 0, 0, 0);
      step("lap_ld", 0, 0, 0, 1, 0, 1, 0, S_IDLE, 0, 1, 42);
      step("lap_after", 0, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 42);
      step("lap_run1", 0, 1, 0, 0, 0, 1, 1, S_RUN, 0, 1, 0);
      step("lap_run2", 0, 1, 0, 0, 0, 1, 2, S_RUN, 0, 1, 1);
      step("lap_run3", 0, 1, 0, 0, 0, 0, 3, S_RUN, 0, 0, 1);
      step("lap_reset", 1, 0, 0, 0, 0, 1, 0, S_IDLE, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
